// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// Single outstanding transfer: a beat completes on an edge with req && ready.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, talks to imem, and drives IF/ID
// load/flush with a one-entry hold buffer for stalls and a kill state for redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    fetch_unit_if.master       imem,
    output logic [31:0]        pc_out,
    output logic [31:0]        instruction_out,
    output logic               if_id_enable,
    output logic               if_id_flush,
    output logic [31:0]        fetch_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] buf_instr, buf_nxt;
    logic [31:0] redir_pc, redir_nxt;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;
    assign fetch_pc = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            buf_instr <= NOP;
            redir_pc  <= 32'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            buf_instr <= buf_nxt;
            redir_pc  <= redir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        buf_nxt   = buf_instr;
        redir_nxt = redir_pc;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem.imem_ready) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        // The in-flight beat must still be drained before retargeting.
                        redir_nxt = redirect_pc;
                        state_nxt = KILL;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        buf_nxt   = imem.imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = FETCH;
                end
            end
            KILL: begin
                if (redirect) begin
                    redir_nxt = redirect_pc;
                end
                if (imem.imem_ready) begin
                    pc_nxt    = redirect ? redirect_pc : redir_pc;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_comb begin
        imem.imem_req   = 1'b0;
        imem.imem_addr  = pc;
        if_id_enable    = 1'b0;
        if_id_flush     = 1'b0;
        pc_out          = 32'd0;
        instruction_out = NOP;
        if (reset) begin
            if_id_flush = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    imem.imem_req = 1'b1;
                    if (redirect) begin
                        if_id_flush = 1'b1;
                    end else if (imem.imem_ready && !stall) begin
                        if_id_enable    = 1'b1;
                        instruction_out = imem.imem_rdata;
                        pc_out          = pc_plus4;
                    end else if (!imem.imem_ready && !stall) begin
                        if_id_flush = 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_id_flush = 1'b1;
                    end else if (!stall) begin
                        if_id_enable    = 1'b1;
                        instruction_out = buf_instr;
                        pc_out          = pc_plus4;
                    end
                end
                KILL: begin
                    imem.imem_req = 1'b1;
                    if_id_flush   = !stall;
                end
                default: begin
                    if_id_flush = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: each record drives one cycle of inputs
// and lists the combinational outputs expected in that cycle.
module tb_fetch_unit;

    localparam logic [31:0] A = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        if_id_enable;
    logic        if_id_flush;
    logic [31:0] fetch_pc;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem.master),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .if_id_enable    (if_id_enable),
        .if_id_flush     (if_id_flush),
        .fetch_pc        (fetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_en;
        logic        e_fl;
        logic [31:0] e_pco;
        logic [31:0] e_ins;
        logic [31:0] e_fpc;
    } vec_t;

    int applied = 0;
    int miscompares = 0;
    vec_t tbl[28];

    function automatic vec_t mk(string nm, logic rst, logic stl, logic rdr, logic [31:0] rpc,
                                logic rdy, logic [31:0] rdata, logic e_req, logic [31:0] e_addr,
                                logic e_en, logic e_fl, logic [31:0] e_pco, logic [31:0] e_ins,
                                logic [31:0] e_fpc);
        vec_t v;
        v.nm = nm; v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
        v.rdy = rdy; v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr;
        v.e_en = e_en; v.e_fl = e_fl; v.e_pco = e_pco; v.e_ins = e_ins; v.e_fpc = e_fpc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        logic bad;
        @(negedge clk);
        reset           = v.rst;
        stall           = v.stl;
        redirect        = v.rdr;
        redirect_pc     = v.rpc;
        imem.imem_ready = v.rdy;
        imem.imem_rdata = v.rdata;
        #2;
        applied++;
        bad = (imem.imem_req !== v.e_req) || (if_id_enable !== v.e_en) ||
              (if_id_flush !== v.e_fl) || (pc_out !== v.e_pco) ||
              (instruction_out !== v.e_ins) || (fetch_pc !== v.e_fpc) ||
              (v.e_req && (imem.imem_addr !== v.e_addr));
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got req=%0b addr=%h en=%0b fl=%0b pco=%h ins=%h fpc=%h; want req=%0b addr=%h en=%0b fl=%0b pco=%h ins=%h fpc=%h",
                     v.nm, imem.imem_req, imem.imem_addr, if_id_enable, if_id_flush, pc_out,
                     instruction_out, fetch_pc, v.e_req, v.e_addr, v.e_en, v.e_fl, v.e_pco,
                     v.e_ins, v.e_fpc);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);

        //             name        rst stl rdr rpc        rdy rdata        req addr       en fl pco        ins          fpc
        tbl[0]  = mk("rst_state",   1, 0, 0, 32'h0,     1, A,            0, 32'h0,     0, 1, 32'h0,     32'h0,       32'h0);
        tbl[1]  = mk("zw_0",        0, 0, 0, 32'h0,     1, A,            1, 32'h0,     1, 0, 32'h4,     A,           32'h0);
        tbl[2]  = mk("zw_4",        0, 0, 0, 32'h0,     1, A | 32'h4,    1, 32'h4,     1, 0, 32'h8,     A | 32'h4,   32'h4);
        tbl[3]  = mk("zw_8",        0, 0, 0, 32'h0,     1, A | 32'h8,    1, 32'h8,     1, 0, 32'hC,     A | 32'h8,   32'h8);
        tbl[4]  = mk("rst_again",   1, 0, 0, 32'h0,     0, 32'h0,        0, 32'h0,     0, 1, 32'h0,     32'h0,       32'hC);
        tbl[5]  = mk("wait_1",      0, 0, 0, 32'h0,     0, 32'h0,        1, 32'h0,     0, 1, 32'h0,     32'h0,       32'h0);
        tbl[6]  = mk("wait_2",      0, 0, 0, 32'h0,     0, 32'h0,        1, 32'h0,     0, 1, 32'h0,     32'h0,       32'h0);
        tbl[7]  = mk("wait_resp",   0, 0, 0, 32'h0,     1, A,            1, 32'h0,     1, 0, 32'h4,     A,           32'h0);
        tbl[8]  = mk("wait_next",   0, 0, 0, 32'h0,     1, A | 32'h4,    1, 32'h4,     1, 0, 32'h8,     A | 32'h4,   32'h4);
        tbl[9]  = mk("stall_resp",  0, 1, 0, 32'h0,     1, A | 32'h8,    1, 32'h8,     0, 0, 32'h0,     32'h0,       32'h8);
        tbl[10] = mk("hold_1",      0, 1, 0, 32'h0,     0, 32'h0,        0, 32'h8,     0, 0, 32'h0,     32'h0,       32'h8);
        tbl[11] = mk("hold_2",      0, 1, 0, 32'h0,     0, 32'h0,        0, 32'h8,     0, 0, 32'h0,     32'h0,       32'h8);
        tbl[12] = mk("hold_rel",    0, 0, 0, 32'h0,     0, 32'h0,        0, 32'h8,     1, 0, 32'hC,     A | 32'h8,   32'h8);
        tbl[13] = mk("after_hold",  0, 0, 0, 32'h0,     1, A | 32'hC,    1, 32'hC,     1, 0, 32'h10,    A | 32'hC,   32'hC);
        tbl[14] = mk("redir_fly",   0, 0, 1, 32'h40,    0, 32'h0,        1, 32'h10,    0, 1, 32'h0,     32'h0,       32'h10);
        tbl[15] = mk("kill_wait",   0, 0, 0, 32'h0,     0, 32'h0,        1, 32'h10,    0, 1, 32'h0,     32'h0,       32'h10);
        tbl[16] = mk("kill_stall",  0, 1, 0, 32'h0,     0, 32'h0,        1, 32'h10,    0, 0, 32'h0,     32'h0,       32'h10);
        tbl[17] = mk("kill_drain",  0, 0, 0, 32'h0,     1, A | 32'h10,   1, 32'h10,    0, 1, 32'h0,     32'h0,       32'h10);
        tbl[18] = mk("post_kill",   0, 0, 0, 32'h0,     1, A | 32'h40,   1, 32'h40,    1, 0, 32'h44,    A | 32'h40,  32'h40);
        tbl[19] = mk("stall_44",    0, 1, 0, 32'h0,     1, A | 32'h44,   1, 32'h44,    0, 0, 32'h0,     32'h0,       32'h44);
        tbl[20] = mk("hold_redir",  0, 1, 1, 32'h80,    0, 32'h0,        0, 32'h44,    0, 1, 32'h0,     32'h0,       32'h44);
        tbl[21] = mk("after_hr",    0, 0, 0, 32'h0,     0, 32'h0,        1, 32'h80,    0, 1, 32'h0,     32'h0,       32'h80);
        tbl[22] = mk("deliver_80",  0, 0, 0, 32'h0,     1, A | 32'h80,   1, 32'h80,    1, 0, 32'h84,    A | 32'h80,  32'h80);
        tbl[23] = mk("redir_kill",  0, 0, 1, 32'h200,   0, 32'h0,        1, 32'h84,    0, 1, 32'h0,     32'h0,       32'h84);
        tbl[24] = mk("rst_in_kill", 1, 0, 0, 32'h0,     0, 32'h0,        0, 32'h84,    0, 1, 32'h0,     32'h0,       32'h84);
        tbl[25] = mk("post_rst",    0, 0, 0, 32'h0,     1, A,            1, 32'h0,     1, 0, 32'h4,     A,           32'h0);
        tbl[26] = mk("redir_rdy",   0, 0, 1, 32'h100,   1, A | 32'h4,    1, 32'h4,     0, 1, 32'h0,     32'h0,       32'h4);
        tbl[27] = mk("at_100",      0, 0, 0, 32'h0,     1, A | 32'h100,  1, 32'h100,   1, 0, 32'h104,   A | 32'h100, 32'h100);

        for (int i = 0; i < 28; i++) apply(tbl[i]);

        // Latest redirect wins while a killed beat is still outstanding.
        apply(mk("kill_r1",    0, 0, 1, 32'h300, 0, 32'h0,       1, 32'h104, 0, 1, 32'h0,   32'h0,       32'h104));
        apply(mk("kill_r2",    0, 0, 1, 32'h400, 0, 32'h0,       1, 32'h104, 0, 1, 32'h0,   32'h0,       32'h104));
        apply(mk("kill_done",  0, 0, 0, 32'h0,   1, 32'hDEAD,    1, 32'h104, 0, 1, 32'h0,   32'h0,       32'h104));
        apply(mk("at_400",     0, 0, 0, 32'h0,   1, A | 32'h400, 1, 32'h400, 1, 0, 32'h404, A | 32'h400, 32'h400));
        // Redirect coinciding with the drain beat overrides the saved target.
        apply(mk("kill_r3",    0, 0, 1, 32'h500, 0, 32'h0,       1, 32'h404, 0, 1, 32'h0,   32'h0,       32'h404));
        apply(mk("kill_r4rdy", 0, 0, 1, 32'h600, 1, 32'hBEEF,    1, 32'h404, 0, 1, 32'h0,   32'h0,       32'h404));
        apply(mk("at_600",     0, 0, 0, 32'h0,   1, A | 32'h600, 1, 32'h600, 1, 0, 32'h604, A | 32'h600, 32'h600));
        // PC wrap at the top of the address space.
        apply(mk("to_top",     0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0, 1, 32'h604, 0, 1, 32'h0,   32'h0,       32'h604));
        apply(mk("wrap",       0, 0, 0, 32'h0,   1, 32'h1234,    1, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h1234, 32'hFFFF_FFFC));
        apply(mk("after_wrap", 0, 0, 0, 32'h0,   1, 32'h5678,    1, 32'h0,   1, 0, 32'h4,   32'h5678,    32'h0));
        // Misaligned target passes through untouched.
        apply(mk("to_203",     0, 0, 1, 32'h203, 1, 32'h0,       1, 32'h4,   0, 1, 32'h0,   32'h0,       32'h4));
        apply(mk("at_203",     0, 0, 0, 32'h0,   1, 32'h9999,    1, 32'h203, 1, 0, 32'h207, 32'h9999,    32'h203));
        // Stall with no response holds IF/ID without a bubble.
        apply(mk("stall_wait", 0, 1, 0, 32'h0,   0, 32'h0,       1, 32'h207, 0, 0, 32'h0,   32'h0,       32'h207));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
